rob_commit_ctrl: RTL and testbench

- In-order commit controller that sequences the register file's write port and rename-tag allocation.
- Circular reorder buffer: hands out tags at decode (drives the register file's rob_free_entry and dc_rd), records results from the completion bus, and retires results in program order.
- Retires at most one result per cycle into the register file (we, write_reg, write_tag, write_data).
- Sits between decode, the completion bus and registerFile; flushes on mispred in lockstep with the register file's tag clear.

---
 rtl/rob_commit_ctrl_if.sv | 31 +++
 rtl/rob_commit_ctrl.sv | 123 ++++++++++++
 tb/tb_rob_commit_ctrl.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/rob_commit_ctrl_if.sv
// Decode allocation, completion bus and register-file write port of rob_commit_ctrl.
// The master side is decode/CDB/register file; the slave side is the controller.
interface rob_commit_ctrl_if #(
    parameter int unsigned TAG_W  = 6,
    parameter int unsigned REG_W  = 6,
    parameter int unsigned DATA_W = 32
);
    logic              alloc_valid;
    logic [REG_W-1:0]  alloc_rd;
    logic              alloc_ready;
    logic [TAG_W-1:0]  alloc_tag;
    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_data;
    logic              we;
    logic [REG_W-1:0]  write_reg;
    logic [TAG_W-1:0]  write_tag;
    logic [DATA_W-1:0] write_data;
    logic [TAG_W:0]    rob_count;
    logic              rob_empty;

    modport master (
        output alloc_valid, alloc_rd, cdb_valid, cdb_tag, cdb_data,
        input  alloc_ready, alloc_tag, we, write_reg, write_tag, write_data, rob_count, rob_empty
    );

    modport slave (
        input  alloc_valid, alloc_rd, cdb_valid, cdb_tag, cdb_data,
        output alloc_ready, alloc_tag, we, write_reg, write_tag, write_data, rob_count, rob_empty
    );
endinterface

// File: rtl/rob_commit_ctrl.sv
// In-order commit controller: circular ROB handing out tags, recording CDB results and
// retiring one entry per cycle into the register file. ROB_BYPASS_EN enables CDB-to-head retire.
module rob_commit_ctrl #(
    parameter int unsigned ROB_DEPTH = 64,
    parameter int unsigned TAG_W     = 6,
    parameter int unsigned REG_W     = 6,
    parameter int unsigned DATA_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mispred,
    rob_commit_ctrl_if.slave  bus
);
    logic [TAG_W:0]     head_q, head_d, tail_q, tail_d, count;
    logic [ROB_DEPTH-1:0] valid_q, valid_d, done_q, done_d;
    logic [REG_W-1:0]   rd_q   [ROB_DEPTH];
    logic [DATA_W-1:0]  data_q [ROB_DEPTH];

    logic               we_q, we_d;
    logic [REG_W-1:0]   write_reg_q, write_reg_d;
    logic [TAG_W-1:0]   write_tag_q, write_tag_d;
    logic [DATA_W-1:0]  write_data_q, write_data_d;

    logic [TAG_W-1:0]   head_idx, tail_idx;
    logic               full, alloc_fire, cdb_hit, commit;
    logic [DATA_W-1:0]  commit_data;

    assign head_idx   = head_q[TAG_W-1:0];
    assign tail_idx   = tail_q[TAG_W-1:0];
    assign count      = tail_q - head_q;
    assign full       = (count == (TAG_W+1)'(ROB_DEPTH));
    assign alloc_fire = bus.alloc_valid && !full && !mispred;
    assign cdb_hit    = bus.cdb_valid && valid_q[bus.cdb_tag];

`ifdef ROB_BYPASS_EN
    // Head still waiting but its result is on the CDB right now: retire straight from the bus.
    logic bypass;
    assign bypass      = valid_q[head_idx] && !done_q[head_idx] && bus.cdb_valid
                         && (bus.cdb_tag == head_idx);
    assign commit      = (valid_q[head_idx] && done_q[head_idx]) || bypass;
    assign commit_data = bypass ? bus.cdb_data : data_q[head_idx];
`else
    assign commit      = valid_q[head_idx] && done_q[head_idx];
    assign commit_data = data_q[head_idx];
`endif

    always_comb begin
        head_d       = head_q;
        tail_d       = tail_q;
        valid_d      = valid_q;
        done_d       = done_q;
        we_d         = 1'b0;
        write_reg_d  = write_reg_q;
        write_tag_d  = write_tag_q;
        write_data_d = write_data_q;
        if (mispred) begin
            head_d  = '0;
            tail_d  = '0;
            valid_d = '0;
            done_d  = '0;
        end else begin
            if (alloc_fire) begin
                valid_d[tail_idx] = 1'b1;
                done_d[tail_idx]  = 1'b0;
                tail_d            = tail_q + 1'b1;
            end
            if (cdb_hit) begin
                done_d[bus.cdb_tag] = 1'b1;
            end
            // Applied last so a bypassed retire overrides the CDB done update.
            if (commit) begin
                valid_d[head_idx] = 1'b0;
                done_d[head_idx]  = 1'b0;
                head_d            = head_q + 1'b1;
                we_d              = (rd_q[head_idx] != '0);
                write_reg_d       = rd_q[head_idx];
                write_tag_d       = head_idx;
                write_data_d      = commit_data;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q       <= '0;
            tail_q       <= '0;
            valid_q      <= '0;
            done_q       <= '0;
            we_q         <= 1'b0;
            write_reg_q  <= '0;
            write_tag_q  <= '0;
            write_data_q <= '0;
        end else begin
            head_q       <= head_d;
            tail_q       <= tail_d;
            valid_q      <= valid_d;
            done_q       <= done_d;
            we_q         <= we_d;
            write_reg_q  <= write_reg_d;
            write_tag_q  <= write_tag_d;
            write_data_q <= write_data_d;
        end
    end

    // Payload storage is qualified by valid, so it needs no reset.
    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            rd_q[tail_idx] <= bus.alloc_rd;
        end
        if (!mispred && cdb_hit) begin
            data_q[bus.cdb_tag] <= bus.cdb_data;
        end
    end

    assign bus.alloc_ready = !full && !mispred;
    assign bus.alloc_tag   = tail_idx;
    assign bus.we          = we_q;
    assign bus.write_reg   = write_reg_q;
    assign bus.write_tag   = write_tag_q;
    assign bus.write_data  = write_data_q;
    assign bus.rob_count   = count;
    assign bus.rob_empty   = (count == '0);
endmodule

// File: tb/tb_rob_commit_ctrl.sv
// Directed bench for rob_commit_ctrl: alloc, out-of-order completion, full/wrap, rd=0,
// mispred flush and asynchronous reset.
module tb_rob_commit_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic mispred = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    rob_commit_ctrl_if #(.TAG_W(6), .REG_W(6), .DATA_W(32)) bus ();

    rob_commit_ctrl #(
        .ROB_DEPTH(64), .TAG_W(6), .REG_W(6), .DATA_W(32)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .mispred(mispred),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_wr(input string tag, input logic w, input logic [5:0] r,
                            input logic [5:0] t, input logic [31:0] d);
        check({tag, ".we"}, 64'(bus.we), 64'(w));
        check({tag, ".reg"}, 64'(bus.write_reg), 64'(r));
        check({tag, ".tag"}, 64'(bus.write_tag), 64'(t));
        check({tag, ".data"}, 64'(bus.write_data), 64'(d));
    endtask

    initial begin
        bus.alloc_valid = 1'b0;
        bus.alloc_rd    = '0;
        bus.cdb_valid   = 1'b0;
        bus.cdb_tag     = '0;
        bus.cdb_data    = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        check_wr("rst", 1'b0, 6'd0, 6'd0, 32'd0);
        check("rst.count", 64'(bus.rob_count), 64'd0);
        check("rst.empty", 64'(bus.rob_empty), 64'd1);
        check("rst.ready", 64'(bus.alloc_ready), 64'd1);
        check("rst.tag", 64'(bus.alloc_tag), 64'd0);

        // Three allocations
        bus.alloc_valid = 1'b1;
        bus.alloc_rd = 6'd5; check("alloc0.tag", 64'(bus.alloc_tag), 64'd0); step();
        bus.alloc_rd = 6'd7; check("alloc1.tag", 64'(bus.alloc_tag), 64'd1); step();
        bus.alloc_rd = 6'd9; check("alloc2.tag", 64'(bus.alloc_tag), 64'd2); step();
        bus.alloc_valid = 1'b0;
        check("alloc.count", 64'(bus.rob_count), 64'd3);
        check("alloc.we", 64'(bus.we), 64'd0);

        // Out-of-order completion, in-order commit
        bus.cdb_valid = 1'b1;
        bus.cdb_tag = 6'd2; bus.cdb_data = 32'hC; step();
        check("cdb2.we", 64'(bus.we), 64'd0);
        bus.cdb_tag = 6'd0; bus.cdb_data = 32'hA; step();
        check("cdb0.we", 64'(bus.we), 64'd0);
        bus.cdb_tag = 6'd1; bus.cdb_data = 32'hB; step();
        bus.cdb_valid = 1'b0;
        check_wr("cm0", 1'b1, 6'd5, 6'd0, 32'hA);
        step();
        check_wr("cm1", 1'b1, 6'd7, 6'd1, 32'hB);
        step();
        check_wr("cm2", 1'b1, 6'd9, 6'd2, 32'hC);
        step();
        check_wr("cm.idle", 1'b0, 6'd9, 6'd2, 32'hC);
        check("cm.count", 64'(bus.rob_count), 64'd0);
        check("cm.empty", 64'(bus.rob_empty), 64'd1);

        // Fill all 64 entries starting at tag 3
        bus.alloc_valid = 1'b1;
        for (int i = 0; i < 64; i++) begin
            bus.alloc_rd = 6'((i % 7) + 1);
            check($sformatf("fill%0d.tag", i), 64'(bus.alloc_tag), 64'((3 + i) % 64));
            step();
        end
        check("full.ready", 64'(bus.alloc_ready), 64'd0);
        check("full.count", 64'(bus.rob_count), 64'd64);
        // Complete head (tag 3) while decode keeps requesting
        bus.cdb_valid = 1'b1; bus.cdb_tag = 6'd3; bus.cdb_data = 32'h33;
        step();
        bus.cdb_valid = 1'b0;
        check("full.ready2", 64'(bus.alloc_ready), 64'd0);
        step();
        check("full.commit_cnt", 64'(bus.rob_count), 64'd63);
        check_wr("full.cm", 1'b1, 6'd1, 6'd3, 32'h33);
        check("wrap.ready", 64'(bus.alloc_ready), 64'd1);
        check("wrap.tag", 64'(bus.alloc_tag), 64'd3);
        step();
        bus.alloc_valid = 1'b0;
        check("wrap.count", 64'(bus.rob_count), 64'd64);

        // Flush the full buffer
        mispred = 1'b1;
        check("flush.ready", 64'(bus.alloc_ready), 64'd0);
        step();
        mispred = 1'b0;
        check("flush.count", 64'(bus.rob_count), 64'd0);
        check("flush.tag", 64'(bus.alloc_tag), 64'd0);
        check("flush.we", 64'(bus.we), 64'd0);

        // rd=0 retires silently
        bus.alloc_valid = 1'b1; bus.alloc_rd = 6'd0; step();
        bus.alloc_valid = 1'b0;
        bus.cdb_valid = 1'b1; bus.cdb_tag = 6'd0; bus.cdb_data = 32'h55; step();
        bus.cdb_valid = 1'b0;
        check("rd0.count_pre", 64'(bus.rob_count), 64'd1);
        step();
        check_wr("rd0", 1'b0, 6'd0, 6'd0, 32'h55);
        check("rd0.count", 64'(bus.rob_count), 64'd0);

        // Four pending, two (non-head) done, then mispred with alloc+cdb
        bus.alloc_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.alloc_rd = 6'(i + 1);
            check($sformatf("mp.alloc%0d", i), 64'(bus.alloc_tag), 64'(i + 1));
            step();
        end
        bus.alloc_valid = 1'b0;
        bus.cdb_valid = 1'b1;
        bus.cdb_tag = 6'd3; bus.cdb_data = 32'h3; step();
        bus.cdb_tag = 6'd4; bus.cdb_data = 32'h4; step();
        check("mp.count_pre", 64'(bus.rob_count), 64'd4);
        mispred = 1'b1;
        bus.alloc_valid = 1'b1; bus.alloc_rd = 6'd6;
        bus.cdb_tag = 6'd1; bus.cdb_data = 32'h1;
        step();
        mispred = 1'b0;
        bus.alloc_valid = 1'b0;
        bus.cdb_valid = 1'b0;
        check("mp.count", 64'(bus.rob_count), 64'd0);
        check("mp.we", 64'(bus.we), 64'd0);
        check("mp.tag", 64'(bus.alloc_tag), 64'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("mp.late%0d", i), 64'(bus.we), 64'd0);
        end
        check("mp.count_post", 64'(bus.rob_count), 64'd0);

        // Async reset while we=1
        bus.alloc_valid = 1'b1;
        bus.alloc_rd = 6'd10; step();
        bus.alloc_rd = 6'd11; step();
        bus.alloc_valid = 1'b0;
        bus.cdb_valid = 1'b1; bus.cdb_tag = 6'd0; bus.cdb_data = 32'h77; step();
        bus.cdb_valid = 1'b0;
        step();
        check_wr("ar.pre", 1'b1, 6'd10, 6'd0, 32'h77);
        check("ar.count_pre", 64'(bus.rob_count), 64'd1);
        #2 reset = 1'b1;
        #1;
        check_wr("ar", 1'b0, 6'd0, 6'd0, 32'd0);
        check("ar.count", 64'(bus.rob_count), 64'd0);
        check("ar.empty", 64'(bus.rob_empty), 64'd1);
        reset = 1'b0;
        step();
        check("ar.ready", 64'(bus.alloc_ready), 64'd1);
        check("ar.tag", 64'(bus.alloc_tag), 64'd0);

`ifdef ROB_BYPASS_EN
        bus.alloc_valid = 1'b1; bus.alloc_rd = 6'd12; step();
        bus.alloc_valid = 1'b0;
        bus.cdb_valid = 1'b1; bus.cdb_tag = 6'd0; bus.cdb_data = 32'h99; step();
        bus.cdb_valid = 1'b0;
        check_wr("byp", 1'b1, 6'd12, 6'd0, 32'h99);
        check("byp.count", 64'(bus.rob_count), 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
